m_issue_ctrl: RTL and testbench

- Initiator-side counterpart of the matrix-array control and sync interfaces.
- Buffers M instructions from the top decoder and issues them to the matrix array over the mValid/mReady/mInst handshake.
- Runs the semaphores behind the array's sync handshakes:
  - AM counter: A-slot producer writes against array reads (amRSync), yielding amEmpty.
  - MV counter: array writes (mvWSync) against downstream vector-unit reads, yielding mvValid.
- Sits in the top controller, beside the instruction decoder.

---
 rtl/m_issue_ctrl.sv | 117 +++++++++++
 tb/tb_m_issue_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_issue_ctrl.sv
// m_issue_ctrl: issue side of the matrix-array control interface.
// Buffers M instructions from the decoder in a small circular FIFO and offers
// them to the array over a valid/ready handshake. It also keeps the two slot
// semaphores that back the array's sync pulses: AM (A-slot producer vs. array
// reads) and MV (array writes vs. vector-unit reads). Every output is decoded
// from registers, so there is no combinational path from any input to any output.
module m_issue_ctrl #(
    parameter int INST_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int AM_SLOTS   = 2,
    parameter int MV_SLOTS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instValid,
    output logic              instReady,
    input  logic [INST_W-1:0] instData,
    output logic              mValid,
    input  logic              mReady,
    output logic [INST_W-1:0] mInst,
    input  logic              amWSync,
    input  logic              amRSync,
    output logic              amEmpty,
    output logic              amFull,
    input  logic              mvWSync,
    input  logic              mvRSync,
    output logic              mvValid,
    output logic              idle,
    output logic [3:0]        err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int AM_W  = $clog2(AM_SLOTS + 1);
    localparam int MV_W  = $clog2(MV_SLOTS + 1);

    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [AM_W-1:0]  AM_MAX    = AM_W'(AM_SLOTS);
    localparam logic [MV_W-1:0]  MV_MAX    = MV_W'(MV_SLOTS);

    // Instruction storage is data only; it is never reset. Reads are masked
    // while the queue is empty so that mInst shows zero then.
    logic [INST_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [AM_W-1:0]   r_am_cnt;
    logic [MV_W-1:0]   r_mv_cnt;
    logic [1:0]        r_err_am;   // [0] underflow, [1] overflow
    logic [1:0]        r_err_mv;   // [0] underflow, [1] overflow

    logic              w_push;
    logic              w_pop;

    assign instReady = (r_count != FIFO_FULL);
    assign mValid    = (r_count != '0);
    assign mInst     = mValid ? r_mem[r_rd_ptr] : '0;

    assign w_push    = instValid && instReady;
    assign w_pop     = mValid && mReady;

    assign amEmpty   = (r_am_cnt == '0);
    assign amFull    = (r_am_cnt == AM_MAX);
    assign mvValid   = (r_mv_cnt != '0);
    assign idle      = (r_count == '0) && (r_am_cnt == '0) && (r_mv_cnt == '0);
    assign err       = {r_err_mv, r_err_am};

    // Queue control: pointers wrap naturally because the depth is a power of
    // two. A push and a pop in the same cycle leave the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Queue storage: capture the offered instruction at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push && !rst) r_mem[r_wr_ptr] <= instData;
    end

    // AM semaphore: a write and a read in the same cycle cancel each other.
    // Out-of-range requests leave the count unchanged and set a sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_am_cnt <= '0;
            r_err_am <= '0;
        end else if (amWSync && !amRSync) begin
            if (r_am_cnt == AM_MAX) r_err_am[1] <= 1'b1;
            else                    r_am_cnt    <= r_am_cnt + AM_W'(1);
        end else if (amRSync && !amWSync) begin
            if (r_am_cnt == '0) r_err_am[0] <= 1'b1;
            else                r_am_cnt    <= r_am_cnt - AM_W'(1);
        end
    end

    // MV semaphore: the same rules, counting O-slots filled by the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mv_cnt <= '0;
            r_err_mv <= '0;
        end else if (mvWSync && !mvRSync) begin
            if (r_mv_cnt == MV_MAX) r_err_mv[1] <= 1'b1;
            else                    r_mv_cnt    <= r_mv_cnt + MV_W'(1);
        end else if (mvRSync && !mvWSync) begin
            if (r_mv_cnt == '0) r_err_mv[0] <= 1'b1;
            else                r_mv_cnt    <= r_mv_cnt - MV_W'(1);
        end
    end

endmodule

// File: tb/tb_m_issue_ctrl.sv
// Testbench for m_issue_ctrl: directed steps from the test plan, followed by
// a randomized run. Each cycle is checked against a queue-and-counter model.
module tb_m_issue_ctrl;

    localparam int INST_W   = 64;
    localparam int DEPTH    = 4;
    localparam int AM_SLOTS = 2;
    localparam int MV_SLOTS = 2;

    logic              clk;
    logic              rst;
    logic              instValid;
    logic              instReady;
    logic [INST_W-1:0] instData;
    logic              mValid;
    logic              mReady;
    logic [INST_W-1:0] mInst;
    logic              amWSync, amRSync, amEmpty, amFull;
    logic              mvWSync, mvRSync, mvValid;
    logic              idle;
    logic [3:0]        err;

    m_issue_ctrl #(
        .INST_W(INST_W), .FIFO_DEPTH(DEPTH), .AM_SLOTS(AM_SLOTS), .MV_SLOTS(MV_SLOTS)
    ) dut (
        .clk(clk), .rst(rst),
        .instValid(instValid), .instReady(instReady), .instData(instData),
        .mValid(mValid), .mReady(mReady), .mInst(mInst),
        .amWSync(amWSync), .amRSync(amRSync), .amEmpty(amEmpty), .amFull(amFull),
        .mvWSync(mvWSync), .mvRSync(mvRSync), .mvValid(mvValid),
        .idle(idle), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the queue content in order, plus slot counts and error flags.
    logic [INST_W-1:0] mq[$];
    int                am_cnt;
    int                mv_cnt;
    logic [3:0]        m_err;

    int n_vec;
    int n_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model with the current inputs, clock the DUT, compare everything.
    task automatic cycle(input string tag);
        bit push, pop;
        push = instValid && (mq.size() < DEPTH);
        pop  = mReady && (mq.size() > 0);
        if (rst) begin
            mq.delete();
            am_cnt = 0;
            mv_cnt = 0;
            m_err  = 4'b0;
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(instData);
            if (amWSync && !amRSync) begin
                if (am_cnt == AM_SLOTS) m_err[1] = 1'b1; else am_cnt++;
            end else if (amRSync && !amWSync) begin
                if (am_cnt == 0) m_err[0] = 1'b1; else am_cnt--;
            end
            if (mvWSync && !mvRSync) begin
                if (mv_cnt == MV_SLOTS) m_err[3] = 1'b1; else mv_cnt++;
            end else if (mvRSync && !mvWSync) begin
                if (mv_cnt == 0) m_err[2] = 1'b1; else mv_cnt--;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".instReady"}, 64'(instReady), 64'(mq.size() < DEPTH));
        chk({tag, ".mValid"},    64'(mValid),    64'(mq.size() > 0));
        chk({tag, ".mInst"},     mInst,          (mq.size() > 0) ? mq[0] : 64'h0);
        chk({tag, ".amEmpty"},   64'(amEmpty),   64'(am_cnt == 0));
        chk({tag, ".amFull"},    64'(amFull),    64'(am_cnt == AM_SLOTS));
        chk({tag, ".mvValid"},   64'(mvValid),   64'(mv_cnt != 0));
        chk({tag, ".idle"},      64'(idle),      64'(mq.size() == 0 && am_cnt == 0 && mv_cnt == 0));
        chk({tag, ".err"},       64'(err),       64'(m_err));
    endtask

    task automatic quiet();
        instValid = 1'b0; mReady = 1'b0;
        amWSync = 1'b0; amRSync = 1'b0; mvWSync = 1'b0; mvRSync = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        am_cnt = 0; mv_cnt = 0; m_err = 4'b0;
        rst = 1'b1; instData = '0;
        quiet();
        cycle("reset");
        cycle("reset2");
        rst = 1'b0;
        chk("rst.mInst", mInst, 64'h0);
        chk("rst.idle", 64'(idle), 64'h1);

        // Single instruction pass-through with mReady held high.
        chk("t1.ready_before", 64'(instReady), 64'h1);
        instValid = 1'b1; instData = 64'hA5A5_0000_0000_0001; mReady = 1'b1;
        cycle("t1.push");
        instValid = 1'b0;
        chk("t1.mInst", mInst, 64'hA5A5_0000_0000_0001);
        chk("t1.mValid", 64'(mValid), 64'h1);
        cycle("t1.pop");
        chk("t1.empty", 64'(mValid), 64'h0);
        chk("t1.idle", 64'(idle), 64'h1);

        // Fill with 1..4 while the array stalls; a fifth offer is refused.
        mReady = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            instValid = 1'b1; instData = 64'(i);
            cycle("t2.fill");
        end
        chk("t2.full", 64'(instReady), 64'h0);
        instData = 64'd5;
        cycle("t2.offer5");
        instValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle("t2.hold");
            chk("t2.hold_mInst", mInst, 64'd1);
        end
        mReady = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t2.order", mInst, 64'(i));
            cycle("t2.drain");
        end
        chk("t2.drained", 64'(mValid), 64'h0);

        // Full queue with offer and accept together, then interleaved traffic across the wrap.
        mReady = 1'b0;
        for (int i = 11; i <= 14; i++) begin
            instValid = 1'b1; instData = 64'(i);
            cycle("t3.fill");
        end
        instData = 64'd15; mReady = 1'b1;
        cycle("t3.fullpop");
        chk("t3.ready_after", 64'(instReady), 64'h1);
        chk("t3.head", mInst, 64'd12);
        for (int i = 15; i <= 18; i++) begin
            instValid = 1'b1; instData = 64'(i); mReady = i[0];
            cycle("t3.mix");
        end
        instValid = 1'b0; mReady = 1'b1;
        for (int i = 0; i < 6; i++) cycle("t3.drain");
        chk("t3.empty", 64'(mValid), 64'h0);

        // AM semaphore: fill, overflow, balanced pulse, then drain and underflow.
        quiet();
        amWSync = 1'b1;
        cycle("t4.w1");
        chk("t4.amEmpty1", 64'(amEmpty), 64'h0);
        cycle("t4.w2");
        chk("t4.amFull", 64'(amFull), 64'h1);
        cycle("t4.w3");
        chk("t4.ovf", 64'(err), 64'h2);
        chk("t4.stay_full", 64'(amFull), 64'h1);
        amRSync = 1'b1;
        cycle("t4.both");
        chk("t4.both_full", 64'(amFull), 64'h1);
        amWSync = 1'b0;
        cycle("t4.r1");
        cycle("t4.r2");
        cycle("t5.unf");
        amRSync = 1'b0;
        chk("t5.am_err", 64'(err), 64'h3);
        chk("t5.amEmpty", 64'(amEmpty), 64'h1);
        mvRSync = 1'b1;
        cycle("t5.mv_unf");
        mvRSync = 1'b0;
        chk("t5.mv_err", 64'(err), 64'h7);
        for (int i = 0; i < 3; i++) cycle("t5.sticky");

        // MV semaphore visibility and idle.
        mvWSync = 1'b1;
        cycle("t6.w");
        mvWSync = 1'b0;
        chk("t6.mvValid", 64'(mvValid), 64'h1);
        chk("t6.busy", 64'(idle), 64'h0);
        mvRSync = 1'b1;
        cycle("t6.r");
        mvRSync = 1'b0;
        chk("t6.mvEmpty", 64'(mvValid), 64'h0);

        // Reset discards a queued instruction and clears errors.
        instValid = 1'b1; instData = 64'hDEAD_BEEF_0000_0042;
        cycle("t7.push");
        instValid = 1'b0;
        rst = 1'b1; mReady = 1'b1;
        cycle("t7.rst");
        rst = 1'b0;
        chk("t7.err_clr", 64'(err), 64'h0);
        chk("t7.discard", 64'(mValid), 64'h0);
        cycle("t7.after");

        // Randomized traffic on all inputs, occasional reset.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            instValid = $urandom_range(0, 1) != 0;
            instData  = {$urandom, $urandom};
            mReady    = $urandom_range(0, 2) != 0;
            amWSync   = $urandom_range(0, 2) == 0;
            amRSync   = $urandom_range(0, 2) == 0;
            mvWSync   = $urandom_range(0, 2) == 0;
            mvRSync   = $urandom_range(0, 2) == 0;
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
